mem_unit: RTL and testbench

- Word-addressed synchronous main memory with a request/done handshake.
- Sits directly downstream of the datapath's MAR and MDR: address comes from MAR, store data comes from MDR.
- Returns the read word on Mdatain, which feeds the MDR load path.
- Inserts programmable wait states so the control FSM must wait on Done; it never assumes a fixed memory latency.

---
 rtl/mem_unit.sv | 149 ++++++++++++++
 tb/tb_mem_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_unit.sv
// Word-addressed synchronous main memory with Read/Write request, programmable wait states and a Done pulse.
// Define MEM_FAULT_EN to flag and suppress accesses whose upper address bits are non-zero.
module mem_unit #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Busy,
  output logic              Done,
  output logic              Fault
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_rd_q, is_rd_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fault_q, fault_d;
  logic                mem_we_c;
  logic [DATA_W-1:0]   mem_q [DEPTH];

`ifdef MEM_FAULT_EN
  logic oor_q, oor_d;
  logic req_oor_c;
  assign req_oor_c = |Address[31:ADDR_W];
`else
  // Upper address bits are ignored so the address wraps modulo DEPTH.
  logic oor_q;
  logic unused_addr_hi;
  assign oor_q          = 1'b0;
  assign unused_addr_hi = |Address[31:ADDR_W];
`endif

  // Next-state, request latching and array access control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_rd_d  = is_rd_q;
    mdata_d  = mdata_q;
    fault_d  = 1'b0;
    mem_we_c = 1'b0;
`ifdef MEM_FAULT_EN
    oor_d    = oor_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Read || Write) begin
          addr_d  = Address[ADDR_W-1:0];
          wdata_d = WriteData;
          is_rd_d = Read;
          cnt_d   = CNT_W'(WAIT_CYCLES);
`ifdef MEM_FAULT_EN
          oor_d   = req_oor_c;
`endif
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        fault_d = oor_q;
        if (is_rd_q) begin
          mdata_d = oor_q ? '0 : mem_q[addr_q];
        end else begin
          mem_we_c = !oor_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_rd_q <= 1'b0;
      mdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_rd_q <= is_rd_d;
      mdata_q <= mdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
    end
  end

`ifdef MEM_FAULT_EN
  always_ff @(posedge Clock) begin
    if (Clear) begin
      oor_q <= 1'b0;
    end else begin
      oor_q <= oor_d;
    end
  end
`endif

  // Array contents survive Clear; a write landing on a Clear edge is dropped.
  always_ff @(posedge Clock) begin
    if (mem_we_c && !Clear) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign Mdatain = mdata_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Fault   = fault_q;

endmodule

// File: tb/tb_mem_unit.sv
// Randomized scoreboard bench for mem_unit: expected responses are queued at issue time and
// checked by a monitor on every Done pulse, including latency and Fault.
module tb_mem_unit;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned WAITC  = 2;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic              clk;
  logic              Clear;
  logic              Read;
  logic              Write;
  logic [31:0]       Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] Mdatain;
  logic              Busy;
  logic              Done;
  logic              Fault;

  mem_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAITC)) dut (
    .Clock(clk), .Clear(Clear), .Read(Read), .Write(Write), .Address(Address),
    .WriteData(WriteData), .Mdatain(Mdatain), .Busy(Busy), .Done(Done), .Fault(Fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] md;
    logic        f;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] last_md;
  int          cyc;
  int          nvec;
  int          nerr;

  initial begin
    cyc = 0; nvec = 0; nerr = 0; last_md = '0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Behavioural memory: a flat word array plus the last read value.
  function automatic void model(input bit rd, input bit wr, input logic [31:0] a,
                                input logic [31:0] d, output logic [31:0] md, output logic f);
    bit oor;
    int idx;
    idx = int'(a % DEPTH);
`ifdef MEM_FAULT_EN
    oor = (a / DEPTH) != 0;
`else
    oor = 1'b0;
`endif
    f = oor;
    if (rd) begin
      last_md = oor ? 32'h0 : mdl[idx];
    end else if (wr && !oor) begin
      mdl[idx] = d;
    end
    md = last_md;
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done: got Done=1 expected no transaction (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("mdatain", Mdatain, e.md);
        chk("fault", 32'(Fault), 32'(e.f));
        chk("done_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit poke, input bit abort);
    exp_t e;
    logic [31:0] md;
    logic        f;
    @(negedge clk);
    Read = rd; Write = wr; Address = a; WriteData = d;
    @(posedge clk);
    #1;
    Read = 1'b0; Write = 1'b0; Address = $urandom; WriteData = $urandom;
    chk("busy_after_req", 32'(Busy), 32'h1);
    if (abort) begin
      repeat (WAITC + 1) @(negedge clk);
      Clear = 1'b1;
      @(negedge clk);
      Clear = 1'b0;
      last_md = '0;
      chk("abort_mdatain", Mdatain, 32'h0);
      chk("abort_busy", 32'(Busy), 32'h0);
      chk("abort_done", 32'(Done), 32'h0);
      return;
    end
    model(rd, wr, a, d, md, f);
    e.md = md; e.f = f; e.cyc = cyc + int'(WAITC) + 1;
    sb_q.push_back(e);
    if (poke) begin
      @(negedge clk);
      Write = 1'b1; Read = $urandom_range(0, 1) == 1; WriteData = $urandom;
      @(negedge clk);
      Write = 1'b0; Read = 1'b0;
    end
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL done_timeout: got no Done expected Done within 40 cycles (cycle %0d)", cyc);
      sb_q.delete();
    end
  endtask

  initial begin
    Clear = 1'b0; Read = 1'b0; Write = 1'b0; Address = '0; WriteData = '0;
    @(negedge clk);
    Clear = 1'b1;
    repeat (2) @(negedge clk);
    Clear = 1'b0;
    chk("reset_mdatain", Mdatain, 32'h0);
    chk("reset_busy", 32'(Busy), 32'h0);
    chk("reset_done", 32'(Done), 32'h0);
    chk("reset_fault", 32'(Fault), 32'h0);

    do_op(0, 1, 32'h10, 32'hDEADBEEF, 0, 0);
    do_op(1, 0, 32'h10, 32'h0, 0, 0);

    for (int i = 0; i < 16; i++) do_op(0, 1, 32'(i), $urandom, 0, 0);
    do_op(0, 1, 32'h1FF, 32'h12345678, 0, 0);
    do_op(1, 0, 32'h1FF, 32'h0, 0, 0);

    // Read wins over a simultaneous write; the array must keep its old word.
    do_op(0, 1, 32'h20, 32'hA5A5A5A5, 0, 0);
    do_op(1, 1, 32'h20, 32'h0, 0, 0);
    do_op(1, 0, 32'h20, 32'h0, 0, 0);

    do_op(0, 1, 32'h5, 32'h55AA55AA, 1, 0);
    do_op(1, 0, 32'h5, 32'h0, 1, 0);

    do_op(0, 1, 32'h30, 32'h11112222, 0, 0);
    do_op(1, 0, 32'h30, 32'h0, 0, 0);
    do_op(0, 1, 32'h30, 32'hCAFEF00D, 0, 1);
    do_op(1, 0, 32'h30, 32'h0, 0, 0);

    do_op(0, 1, 32'h0, 32'h0BADC0DE, 0, 0);
    do_op(0, 1, 32'h200, 32'h77777777, 0, 0);
    do_op(1, 0, 32'h200, 32'h0, 0, 0);
    do_op(1, 0, 32'h0, 32'h0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      bit rd;
      bit wr;
      a = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom << ADDR_W);
      rd = $urandom_range(0, 1) == 1;
      wr = !rd || ($urandom_range(0, 3) == 0);
      do_op(rd, wr, a, $urandom, $urandom_range(0, 2) == 0, 0);
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
